// File: rtl/emperor_axi_lite_pkg.sv
// Shared types and widths for the AXI4-Lite to register-bus bridge.
package emperor_axi_lite_pkg;

  localparam int unsigned AxiAddrW = 32;
  localparam int unsigned AxiDataW = 32;
  localparam int unsigned AxiStrbW = AxiDataW / 8;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StRdReq,
    StWrResp,
    StRdResp
  } bridge_state_e;

endpackage

// File: rtl/emperor_axi_lite_hold_reg.sv
// One-entry valid/ready holding register. ready_o comes straight from a flop,
// so there is no combinational valid->ready path; it is low during reset.
module emperor_axi_lite_hold_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         pop_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_d, full_q;
  logic         ready_q;
  logic [W-1:0] data_d, data_q;

  // Capture on handshake, release on pop (the two never coincide: capture needs empty).
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (valid_i && ready_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  // Entry state; ready tracks the next-cycle emptiness so it re-asserts the cycle after a pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
    end else begin
      full_q  <= full_d;
      ready_q <= !full_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = ready_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/emperor_axi_lite_reg_bridge.sv
// AXI4-Lite slave that turns each access into one req/ack register-bus transfer.
// Handles window decode, read/write round-robin, request timeout and AXI responses.
module emperor_axi_lite_reg_bridge
  import emperor_axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              aclk,
  input  logic              arst_n,
  input  logic [31:0]       S_AXI_awaddr,
  input  logic [2:0]        S_AXI_awprot,
  input  logic              S_AXI_awvalid,
  output logic              S_AXI_awready,
  input  logic [31:0]       S_AXI_wdata,
  input  logic [3:0]        S_AXI_wstrb,
  input  logic              S_AXI_wvalid,
  output logic              S_AXI_wready,
  output logic [1:0]        S_AXI_bresp,
  output logic              S_AXI_bvalid,
  input  logic              S_AXI_bready,
  input  logic [31:0]       S_AXI_araddr,
  input  logic [2:0]        S_AXI_arprot,
  input  logic              S_AXI_arvalid,
  output logic              S_AXI_arready,
  output logic [31:0]       S_AXI_rdata,
  output logic [1:0]        S_AXI_rresp,
  output logic              S_AXI_rvalid,
  input  logic              S_AXI_rready,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  output logic [3:0]        reg_wstrb,
  input  logic              reg_ack,
  input  logic [31:0]       reg_rdata,
  input  logic              reg_err
);

  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  // reg_req stays high for exactly TIMEOUT cycles when no ack arrives.
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT - 1);

  logic                         aw_full, w_full, ar_full;
  logic [AxiAddrW-1:0]          aw_addr, ar_addr;
  logic [AxiStrbW+AxiDataW-1:0] w_bits;
  logic                         grant_wr, grant_rd;
  logic                         wr_hit, rd_hit, tmo;

  bridge_state_e   state_q;
  logic            wr_first_q;
  logic [CntW-1:0] cnt_q;
  logic            reg_req_q, reg_we_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [31:0]     reg_wdata_q;
  logic [3:0]      reg_wstrb_q;
  logic            bvalid_q, rvalid_q;
  resp_e           bresp_q, rresp_q;
  logic [31:0]     rdata_q;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_awprot, S_AXI_arprot, aw_addr[1:0], ar_addr[1:0]};

  emperor_axi_lite_hold_reg #(.W(AxiAddrW)) u_aw_hold (
    .clk_i  (aclk),
    .rst_ni (arst_n),
    .data_i (S_AXI_awaddr),
    .valid_i(S_AXI_awvalid),
    .ready_o(S_AXI_awready),
    .pop_i  (grant_wr),
    .full_o (aw_full),
    .data_o (aw_addr)
  );

  emperor_axi_lite_hold_reg #(.W(AxiStrbW + AxiDataW)) u_w_hold (
    .clk_i  (aclk),
    .rst_ni (arst_n),
    .data_i ({S_AXI_wstrb, S_AXI_wdata}),
    .valid_i(S_AXI_wvalid),
    .ready_o(S_AXI_wready),
    .pop_i  (grant_wr),
    .full_o (w_full),
    .data_o (w_bits)
  );

  emperor_axi_lite_hold_reg #(.W(AxiAddrW)) u_ar_hold (
    .clk_i  (aclk),
    .rst_ni (arst_n),
    .data_i (S_AXI_araddr),
    .valid_i(S_AXI_arvalid),
    .ready_o(S_AXI_arready),
    .pop_i  (grant_rd),
    .full_o (ar_full),
    .data_o (ar_addr)
  );

  assign wr_hit = (aw_addr[AxiAddrW-1:ADDR_W] == BASE_ADDR[AxiAddrW-1:ADDR_W]);
  assign rd_hit = (ar_addr[AxiAddrW-1:ADDR_W] == BASE_ADDR[AxiAddrW-1:ADDR_W]);
  assign tmo    = (TIMEOUT != 0) && (cnt_q == TmoLast);

  // Grant selection in IDLE; the pointer only breaks ties between a pending write and read.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == StIdle) begin
      if (aw_full && w_full && ar_full) begin
        grant_wr = wr_first_q;
        grant_rd = !wr_first_q;
      end else begin
        grant_wr = aw_full && w_full;
        grant_rd = ar_full;
      end
    end
  end

  // Bridge FSM with registered register-bus and AXI response outputs.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      wr_first_q  <= 1'b1;
      cnt_q       <= '0;
      reg_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RespOkay;
      rvalid_q    <= 1'b0;
      rresp_q     <= RespOkay;
      rdata_q     <= '0;
    end else begin
      // Pointer flips only on contested grants so the loser wins the next tie.
      if (grant_wr && ar_full) begin
        wr_first_q <= 1'b0;
      end else if (grant_rd && aw_full && w_full) begin
        wr_first_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (grant_wr) begin
            if (wr_hit) begin
              state_q     <= StWrReq;
              reg_req_q   <= 1'b1;
              reg_we_q    <= 1'b1;
              reg_addr_q  <= {aw_addr[ADDR_W-1:2], 2'b00};
              reg_wdata_q <= w_bits[AxiDataW-1:0];
              reg_wstrb_q <= w_bits[AxiStrbW+AxiDataW-1:AxiDataW];
              cnt_q       <= '0;
            end else begin
              state_q  <= StWrResp;
              bvalid_q <= 1'b1;
              bresp_q  <= RespDecErr;
            end
          end else if (grant_rd) begin
            if (rd_hit) begin
              state_q    <= StRdReq;
              reg_req_q  <= 1'b1;
              reg_we_q   <= 1'b0;
              reg_addr_q <= {ar_addr[ADDR_W-1:2], 2'b00};
              cnt_q      <= '0;
            end else begin
              state_q  <= StRdResp;
              rvalid_q <= 1'b1;
              rresp_q  <= RespDecErr;
              rdata_q  <= '0;
            end
          end
        end
        StWrReq: begin
          // An ack in the final timeout cycle still wins.
          if (reg_ack || tmo) begin
            state_q   <= StWrResp;
            reg_req_q <= 1'b0;
            reg_we_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (reg_ack && !reg_err) ? RespOkay : RespSlvErr;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRdReq: begin
          if (reg_ack || tmo) begin
            state_q   <= StRdResp;
            reg_req_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rresp_q   <= (reg_ack && !reg_err) ? RespOkay : RespSlvErr;
            rdata_q   <= reg_ack ? reg_rdata : '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWrResp: begin
          if (S_AXI_bready) begin
            state_q  <= StIdle;
            bvalid_q <= 1'b0;
          end
        end
        StRdResp: begin
          if (S_AXI_rready) begin
            state_q  <= StIdle;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign reg_req      = reg_req_q;
  assign reg_we       = reg_we_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign reg_wstrb    = reg_wstrb_q;
  assign S_AXI_bvalid = bvalid_q;
  assign S_AXI_bresp  = bresp_q;
  assign S_AXI_rvalid = rvalid_q;
  assign S_AXI_rresp  = rresp_q;
  assign S_AXI_rdata  = rdata_q;

endmodule

// File: tb/tb_emperor_axi_lite_reg_bridge.sv
// Scoreboard bench: issuers push expected register accesses and AXI responses,
// independent monitors pop and compare as the DUT presents them.
module tb_emperor_axi_lite_reg_bridge;

  localparam int unsigned TMO   = 4;
  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          NOACK = -1;
  localparam int          KEEP  = -2;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          delay;
    logic        err;
    logic [31:0] rdata;
  } reg_exp_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        reg_req, reg_we;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack = 1'b0, reg_err = 1'b0;
  logic [31:0] reg_rdata = '0;
  logic [90:0] outvec;

  reg_exp_t reg_wq[$], reg_rq[$];
  rsp_t     b_q[$], r_q[$];
  int       order_q[$];
  int       n_cmp = 0, n_bad = 0;
  int       ready_mode = 0;

  emperor_axi_lite_reg_bridge #(
    .ADDR_W   (12),
    .BASE_ADDR(BASE),
    .TIMEOUT  (TMO)
  ) dut (
    .aclk         (aclk),
    .arst_n       (arst_n),
    .S_AXI_awaddr (awaddr),
    .S_AXI_awprot (3'b000),
    .S_AXI_awvalid(awvalid),
    .S_AXI_awready(awready),
    .S_AXI_wdata  (wdata),
    .S_AXI_wstrb  (wstrb),
    .S_AXI_wvalid (wvalid),
    .S_AXI_wready (wready),
    .S_AXI_bresp  (bresp),
    .S_AXI_bvalid (bvalid),
    .S_AXI_bready (bready),
    .S_AXI_araddr (araddr),
    .S_AXI_arprot (3'b000),
    .S_AXI_arvalid(arvalid),
    .S_AXI_arready(arready),
    .S_AXI_rdata  (rdata),
    .S_AXI_rresp  (rresp),
    .S_AXI_rvalid (rvalid),
    .S_AXI_rready (rready),
    .reg_req      (reg_req),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_wstrb    (reg_wstrb),
    .reg_ack      (reg_ack),
    .reg_rdata    (reg_rdata),
    .reg_err      (reg_err)
  );

  assign outvec = {awready, wready, arready, bvalid, rvalid, reg_req, reg_we, bresp, rresp,
                   rdata, reg_addr, reg_wdata, reg_wstrb};

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic in_window(input logic [31:0] addr);
    return (addr - BASE) < 32'h1000;
  endfunction

  task automatic drive_aw(input logic [31:0] addr, input int gap);
    bit hs; int n;
    repeat (gap) begin @(posedge aclk); #1; end
    awaddr = addr; awvalid = 1'b1; n = 0;
    do begin @(negedge aclk); hs = awready; @(posedge aclk); #1; n++; end while (!hs && n < 300);
    if (!hs) check("awready wait", 0, 1);
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int gap);
    bit hs; int n;
    repeat (gap) begin @(posedge aclk); #1; end
    wdata = data; wstrb = strb; wvalid = 1'b1; n = 0;
    do begin @(negedge aclk); hs = wready; @(posedge aclk); #1; n++; end while (!hs && n < 300);
    if (!hs) check("wready wait", 0, 1);
    wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [31:0] addr, input int gap);
    bit hs; int n;
    repeat (gap) begin @(posedge aclk); #1; end
    araddr = addr; arvalid = 1'b1; n = 0;
    do begin @(negedge aclk); hs = arready; @(posedge aclk); #1; n++; end while (!hs && n < 300);
    if (!hs) check("arready wait", 0, 1);
    arvalid = 1'b0;
  endtask

  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int delay, input logic err,
                             input int gap_aw, input int gap_w);
    reg_exp_t e; rsp_t r;
    if (in_window(addr)) begin
      e.addr = addr[11:0] & 12'hFFC; e.data = data; e.strb = strb;
      e.delay = delay; e.err = err; e.rdata = '0;
      reg_wq.push_back(e);
      r.resp = (delay == NOACK || err) ? 2'b10 : 2'b00;
    end else begin
      r.resp = 2'b11;
    end
    r.data = '0;
    b_q.push_back(r);
    fork
      drive_aw(addr, gap_aw);
      drive_w(data, strb, gap_w);
    join
  endtask

  task automatic issue_read(input logic [31:0] addr, input int delay, input logic err,
                            input logic [31:0] rd, input int gap, input bit push_rsp);
    reg_exp_t e; rsp_t r;
    if (in_window(addr)) begin
      e.addr = addr[11:0] & 12'hFFC; e.data = '0; e.strb = '0;
      e.delay = delay; e.err = err; e.rdata = rd;
      reg_rq.push_back(e);
      if (delay == NOACK) begin r.resp = 2'b10; r.data = '0; end
      else begin r.resp = err ? 2'b10 : 2'b00; r.data = rd; end
    end else begin
      r.resp = 2'b11; r.data = '0;
    end
    if (push_rsp) r_q.push_back(r);
    drive_ar(addr, gap);
  endtask

  task automatic drain();
    int n = 0;
    while ((b_q.size() + r_q.size() + reg_wq.size() + reg_rq.size()) != 0 && n < 2000) begin
      @(posedge aclk); n++;
    end
    check("queues drained", b_q.size() + r_q.size() + reg_wq.size() + reg_rq.size(), 0);
    @(posedge aclk); #1;
  endtask

  // Peripheral model: checks each request against the plan and acks per its delay.
  initial begin
    reg_exp_t e; int n; bit ok;
    forever begin
      @(negedge aclk);
      if (reg_req && arst_n) begin
        order_q.push_back(reg_we ? 2 : 1);
        ok = 1'b0;
        if (reg_we) begin
          if (reg_wq.size() > 0) begin
            e = reg_wq.pop_front(); ok = 1'b1;
            check("reg write addr/data/strb", {reg_addr, reg_wdata, reg_wstrb},
                  {e.addr, e.data, e.strb});
          end
        end else if (reg_rq.size() > 0) begin
          e = reg_rq.pop_front(); ok = 1'b1;
          check("reg read addr", reg_addr, e.addr);
        end
        if (!ok) begin
          check("unexpected reg access (we,addr)", {1'b1, reg_we, reg_addr}, 0);
          n = 0;
          while (reg_req && n < 64) begin @(negedge aclk); n++; end
        end else if (e.delay >= 0) begin
          repeat (e.delay) @(negedge aclk);
          reg_ack = 1'b1; reg_rdata = e.rdata; reg_err = e.err;
          @(posedge aclk); #1;
          reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = $urandom;
        end else begin
          n = 1;
          while (reg_req && n < 64) begin @(negedge aclk); if (reg_req) n++; end
          if (e.delay == NOACK) begin
            check("reg_req cycles before timeout", n, TMO);
            // A late ack with reg_req low must be ignored.
            reg_ack = 1'b1; reg_err = 1'b0;
            @(posedge aclk); #1;
            reg_ack = 1'b0;
          end
        end
      end
    end
  end

  // Response ready generation.
  initial forever begin
    @(posedge aclk); #1;
    case (ready_mode)
      0:       {bready, rready} = 2'b11;
      1:       {bready, rready} = 2'($urandom_range(3));
      default: {bready, rready} = 2'b00;
    endcase
  end

  // B channel monitor.
  initial begin
    bit stall = 1'b0; logic [1:0] prev = '0; rsp_t r;
    forever begin
      @(negedge aclk);
      if (!arst_n) stall = 1'b0;
      else begin
        if (stall) check("b held while stalled", {bvalid, bresp}, {1'b1, prev});
        stall = 1'b0;
        if (bvalid) begin
          if (bready) begin
            if (b_q.size() > 0) begin r = b_q.pop_front(); check("bresp", bresp, r.resp); end
            else check("unexpected bvalid (bresp)", {1'b1, bresp}, 0);
          end else begin
            stall = 1'b1; prev = bresp;
          end
        end
      end
    end
  end

  // R channel monitor.
  initial begin
    bit stall = 1'b0; logic [33:0] prev = '0; rsp_t r;
    forever begin
      @(negedge aclk);
      if (!arst_n) stall = 1'b0;
      else begin
        if (stall) check("r held while stalled", {rvalid, rresp, rdata}, {1'b1, prev});
        stall = 1'b0;
        if (rvalid) begin
          if (rready) begin
            if (r_q.size() > 0) begin
              r = r_q.pop_front();
              check("rresp/rdata", {rresp, rdata}, {r.resp, r.data});
            end else check("unexpected rvalid (rresp,rdata)", {1'b1, rresp, rdata}, 0);
          end else begin
            stall = 1'b1; prev = {rresp, rdata};
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ord, n;
    repeat (3) @(posedge aclk); #1;
    check("outputs in reset", outvec, 0);
    @(negedge aclk); arst_n = 1'b1;
    @(posedge aclk); #1;
    check("ready after reset", {awready, wready, arready}, 3'b111);

    // Contested arbitration, twice.
    for (int k = 0; k < 2; k++) begin
      order_q.delete();
      fork
        issue_write(BASE + 32'h20, $urandom, 4'hF, 0, 1'b0, 0, 0);
        issue_read(BASE + 32'h24, 0, 1'b0, $urandom, 0, 1'b1);
      join
      drain();
      ord = 0;
      foreach (order_q[i]) ord = ord * 10 + order_q[i];
      check(k == 0 ? "contested order first" : "contested order second", ord,
            k == 0 ? 21 : 12);
    end

    issue_write(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 0, 0);
    drain();

    // W three cycles ahead of AW.
    fork
      issue_write(32'h4000_0100, 32'hCAFE_F00D, 4'h5, 0, 1'b0, 3, 0);
      begin
        @(negedge aclk);
        for (int i = 1; i <= 5; i++) begin
          @(negedge aclk);
          check("wready/reg_req while AW late", {wready, reg_req}, (i < 5) ? 2'b00 : 2'b11);
        end
      end
    join
    drain();

    issue_read(32'h4000_0FFC, 0, 1'b1, 32'h1234_5678, 0, 1'b1);
    drain();
    issue_read(32'h5000_0000, 0, 1'b0, 32'h0, 0, 1'b1);
    drain();
    issue_write(BASE + 32'h30, 32'h0BAD_0BAD, 4'h3, NOACK, 1'b0, 0, 0);
    drain();
    issue_read(BASE + 32'h34, NOACK, 1'b0, 32'h5555_AAAA, 0, 1'b1);
    drain();

    // Stalled write response.
    ready_mode = 2;
    issue_write(BASE + 32'h44, 32'h7777_0000, 4'hC, 2, 1'b1, 0, 0);
    n = 0;
    while (!bvalid && n < 50) begin @(posedge aclk); n++; end
    check("bvalid arrives for stalled write", bvalid, 1'b1);
    repeat (10) @(negedge aclk);
    ready_mode = 0;
    @(posedge aclk); #1;
    drain();

    // Randomised traffic.
    ready_mode = 1;
    fork
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a; int d;
        a = ($urandom_range(7) == 0) ? (32'h8000_0000 | $urandom) : BASE + $urandom_range(4095);
        d = ($urandom_range(7) == 0) ? NOACK : $urandom_range(3);
        issue_write(a, $urandom, 4'($urandom), d, 1'($urandom), $urandom_range(3),
                    $urandom_range(3));
      end
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a; int d;
        a = ($urandom_range(7) == 0) ? (32'h8000_0000 | $urandom) : BASE + $urandom_range(4095);
        d = ($urandom_range(7) == 0) ? NOACK : $urandom_range(3);
        issue_read(a, d, 1'($urandom), $urandom, $urandom_range(3), 1'b1);
      end
    join
    ready_mode = 0;
    drain();

    // Reset while a read waits in RD_REQ.
    issue_read(BASE + 32'h40, KEEP, 1'b0, 32'h0, 0, 1'b0);
    n = 0;
    do begin @(negedge aclk); n++; end while (!reg_req && n < 20);
    check("reg_req before mid-reset", reg_req, 1'b1);
    #2 arst_n = 1'b0;
    #1 check("outputs after mid-transaction reset", outvec, 0);
    repeat (2) @(negedge aclk);
    arst_n = 1'b1;
    @(posedge aclk); #1;
    repeat (3) begin @(negedge aclk); check("no response after reset", {rvalid, bvalid}, 2'b00); end
    @(posedge aclk); #1;
    issue_read(BASE + 32'h48, 0, 1'b0, 32'hFACE_B00C, 0, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
